butterfly_cplx_pipe: RTL and testbench
======================================

Name: butterfly_cplx_pipe

Overview:
- Parametrised successor to the fixed stage-2 butterfly of the 8-point FFT.
- Takes a complex pair a and b and computes y1 = a + T*b and y2 = a - T*b.
- T is a per-sample trivial twiddle from the set {1, -j, -1, +j}, so the block needs no multipliers.
- Two-stage valid/ready pipeline with back-pressure, selectable scaling or saturation, and a sticky overflow flag. Usable in any radix-2 FFT stage whose twiddles are trivial.

Parameters:
- DW, 16: signed two's-complement width of every real and imaginary data port.
- SCALE, 0: 1 = outputs are divided by 2 (arithmetic shift right, floor), never overflow; 0 = outputs are saturated to DW bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept an input this cycle.
- ar, ai  in  DW each  real and imaginary parts of a.
- br, bi  in  DW each  real and imaginary parts of b.
- tw_sel  in  2  twiddle select: 0 = 1, 1 = -j, 2 = -1, 3 = +j.
- out_valid  out  1  outputs valid.
- out_ready  in  1  downstream accepts the outputs this cycle.
- yr1, yi1  out  DW each  real and imaginary parts of y1 = a + T*b.
- yr2, yi2  out  DW each  real and imaginary parts of y2 = a - T*b.
- ovf  out  1  sticky saturation flag (only meaningful when SCALE=0).
- ovf_clr  in  1  synchronous clear of ovf.

Behaviour:
- Reset (rst=0, asynchronous): both stage valid bits = 0, all data registers = 0, ovf = 0. Outputs are therefore out_valid=0 and y*=0, while in_ready = 1.
- Handshake:
  - An input transfers when in_valid & in_ready are both high; an output transfers when out_valid & out_ready are both high.
  - Stage k advances when it is empty or stage k+1 will advance this cycle.
  - in_ready = !s1_valid | s1_advance; s2 advances when !s2_valid | out_ready.
  - Full throughput: 1 sample per cycle. Latency: 2 cycles from input transfer to out_valid.
  - Data and out_valid hold stable while out_valid & !out_ready.
  - No combinational path from in_valid to out_valid. in_ready depends combinationally on out_ready; this path is accepted.
- Stage 1 (register): rotate b by T into DW+1 bits (sign-extended), so negating -2^(DW-1) cannot wrap.
  - T=1: (br, bi)
  - T=-j: (bi, -br)
  - T=-1: (-br, -bi)
  - T=+j: (-bi, br)
  - Register a, sign-extended to DW+1 bits, alongside the rotated b.
- Stage 2 (register): form s = a + rb and d = a - rb per component in DW+1 bits; the result is exact.
  - SCALE=1: output = s[DW:1] (floor divide by 2).
  - SCALE=0: output = s clamped to [-2^(DW-1), 2^(DW-1)-1].
  - Any clamp on a transferring stage-2 update sets ovf.
- ovf: set on a saturation event, cleared by ovf_clr. If set and clear happen in the same cycle, set wins. ovf never sets when SCALE=1.
- tw_sel is sampled with the input data at the stage-1 transfer. It may change every sample.
- Bubbles: s1 may be empty while s2 holds data stalled by out_ready; a new input fills s1 and no data is lost or duplicated.
- A reset mid-stream discards all in-flight samples; no output is produced for them.

Decomposition:
- Shared package fft_pkg holds:
  - the twiddle encoding constants TW_ONE=0, TW_NJ=1, TW_NEG=2, TW_PJ=3
  - a sat_dw function (DW+1 to DW clamp)
- Natural sub-module: cplx_rot_trivial (combinational rotation of b by tw_sel, DW to DW+1 bits), instantiated once in stage 1.
- Pipeline registers stay inline. The existing reg_n is not used because it lacks enable and async active-low reset.

Test Plan:
- Reset: hold rst=0 with in_valid=1 -> out_valid=0, y*=0, ovf=0; release rst -> first out_valid exactly 2 cycles after the first accepted input.
- Twiddles (DW=16, SCALE=0): a=(100,50), b=(10,20), out_ready=1, tw_sel=0,1,2,3 back-to-back.
  - tw_sel=0 -> y1=(110,70), y2=(90,30)
  - tw_sel=1 -> y1=(120,40), y2=(80,60)
  - tw_sel=2 -> y1=(90,30), y2=(110,70)
  - tw_sel=3 -> y1=(80,60), y2=(120,40)
  - Outputs on consecutive cycles.
- Saturation (SCALE=0): a=(32767,-32768), b=(1,1), tw_sel=0 -> yr1=32767, yi1=-32767, yr2=32766, yi2=-32768 (clamped), ovf=1. ovf stays 1 until ovf_clr; ovf_clr together with a new saturation keeps ovf=1.
- Negation corner (SCALE=1): b=(-32768,0), a=(0,0), tw_sel=2 -> y1=(16384,0), y2=(-16384,0), ovf=0.
- Back-pressure: stream 8 samples with out_ready pattern 1,0,0,1,0,1,1,1 -> all 8 outputs in order, no loss or duplication; y* stable during stall; in_ready=0 whenever both stages are full and out_ready=0.
- Mid-stream reset: assert rst=0 with 2 samples in flight -> out_valid drops immediately (asynchronously); after release, none of the discarded samples appear.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the trivial-twiddle FFT butterflies.
//   TW_*      : encoding of tw_sel (0 = 1, 1 = -j, 2 = -1, 3 = +j)
//   MAX_DW    : widest data path supported by sat_dw
//   sat_dw()  : clamps a sign-extended (DW+1)-bit value to the signed DW-bit range
package fft_pkg;

    localparam logic [1:0] TW_ONE = 2'd0;
    localparam logic [1:0] TW_NJ  = 2'd1;
    localparam logic [1:0] TW_NEG = 2'd2;
    localparam logic [1:0] TW_PJ  = 2'd3;

    localparam int MAX_DW = 32;

    typedef logic signed [MAX_DW:0] sat_w_t;

    // Callers sign-extend their DW+1 bit value into sat_w_t and take the low
    // DW bits of the result; a difference between input and result flags a clamp.
    function automatic sat_w_t sat_dw(input sat_w_t s, input int unsigned dw);
        sat_w_t hi;
        sat_w_t lo;
        hi = (sat_w_t'(1) <<< (dw - 1)) - sat_w_t'(1);
        lo = ~hi;
        if (s > hi) begin
            sat_dw = hi;
        end else if (s < lo) begin
            sat_dw = lo;
        end else begin
            sat_dw = s;
        end
    endfunction

endpackage

// File: rtl/cplx_rot_trivial.sv
// Combinational rotation of a complex sample by a trivial twiddle.
//   tw_sel  in  2     twiddle select (TW_ONE, TW_NJ, TW_NEG, TW_PJ)
//   br, bi  in  DW    real / imaginary input
//   rr, ri  out DW+1  rotated real / imaginary, one bit wider so -(-2^(DW-1)) is exact
module cplx_rot_trivial
    import fft_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [1:0]           tw_sel,
    input  logic signed [DW-1:0] br,
    input  logic signed [DW-1:0] bi,
    output logic signed [DW:0]   rr,
    output logic signed [DW:0]   ri
);

    logic signed [DW:0] br_x;
    logic signed [DW:0] bi_x;

    assign br_x = {br[DW-1], br};
    assign bi_x = {bi[DW-1], bi};

    always_comb begin
        rr = br_x;
        ri = bi_x;
        unique case (tw_sel)
            TW_ONE: begin
                rr = br_x;
                ri = bi_x;
            end
            TW_NJ: begin
                rr = bi_x;
                ri = -br_x;
            end
            TW_NEG: begin
                rr = -br_x;
                ri = -bi_x;
            end
            TW_PJ: begin
                rr = -bi_x;
                ri = br_x;
            end
        endcase
    end

endmodule

// File: rtl/butterfly_cplx_pipe.sv
// Two-stage valid/ready radix-2 butterfly with trivial twiddles:
//   y1 = a + T*b, y2 = a - T*b, T in {1, -j, -1, +j}.
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   in_valid / in_ready  input handshake (in_ready follows out_ready combinationally)
//   ar, ai, br, bi       complex inputs a and b, signed DW bits
//   tw_sel               twiddle select, sampled with the input data
//   out_valid / out_ready output handshake
//   yr1, yi1, yr2, yi2   complex outputs y1 and y2, signed DW bits
//   ovf / ovf_clr        sticky saturation flag and its synchronous clear
// SCALE=1 halves the outputs (floor) so they cannot overflow; SCALE=0 saturates.
module butterfly_cplx_pipe
    import fft_pkg::*;
#(
    parameter int DW    = 16,
    parameter bit SCALE = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] ar,
    input  logic signed [DW-1:0] ai,
    input  logic signed [DW-1:0] br,
    input  logic signed [DW-1:0] bi,
    input  logic [1:0]           tw_sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] yr1,
    output logic signed [DW-1:0] yi1,
    output logic signed [DW-1:0] yr2,
    output logic signed [DW-1:0] yi2,
    output logic                 ovf,
    input  logic                 ovf_clr
);

    logic               s1_valid;
    logic               s2_valid;
    logic               s1_adv;
    logic               s2_adv;
    logic               s1_load;
    logic               s2_load;

    logic signed [DW:0] rot_r;
    logic signed [DW:0] rot_i;
    logic signed [DW:0] s1_ar;
    logic signed [DW:0] s1_ai;
    logic signed [DW:0] s1_rr;
    logic signed [DW:0] s1_ri;

    // res order: y1 real, y1 imag, y2 real, y2 imag
    logic signed [DW:0]   res    [4];
    logic signed [DW-1:0] y_next [4];
    logic [3:0]           sat;

    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;
    assign s1_load  = in_valid && s1_adv;
    assign s2_load  = s1_valid && s2_adv;

    cplx_rot_trivial #(.DW(DW)) u_rot (
        .tw_sel (tw_sel),
        .br     (br),
        .bi     (bi),
        .rr     (rot_r),
        .ri     (rot_i)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_ar    <= '0;
            s1_ai    <= '0;
            s1_rr    <= '0;
            s1_ri    <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
            end
            // data only moves on a real transfer so bubbles leave it untouched
            if (s1_load) begin
                s1_ar <= {ar[DW-1], ar};
                s1_ai <= {ai[DW-1], ai};
                s1_rr <= rot_r;
                s1_ri <= rot_i;
            end
        end
    end

    // |a| <= 2^(DW-1) and |rb| <= 2^(DW-1), so DW+1 bits hold every sum exactly
    assign res[0] = s1_ar + s1_rr;
    assign res[1] = s1_ai + s1_ri;
    assign res[2] = s1_ar - s1_rr;
    assign res[3] = s1_ai - s1_ri;

    for (genvar k = 0; k < 4; k++) begin : g_out
        if (SCALE) begin : g_scale
            logic unused_lsb;
            assign unused_lsb = res[k][0];
            assign y_next[k]  = res[k][DW:1];
            assign sat[k]     = 1'b0;
        end else begin : g_sat
            sat_w_t wide;
            sat_w_t clamped;
            assign wide      = sat_w_t'(res[k]);
            assign clamped   = sat_dw(wide, DW);
            assign y_next[k] = clamped[DW-1:0];
            assign sat[k]    = (clamped != wide);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            yr1      <= '0;
            yi1      <= '0;
            yr2      <= '0;
            yi2      <= '0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
            end
            if (s2_load) begin
                yr1 <= y_next[0];
                yi1 <= y_next[1];
                yr2 <= y_next[2];
                yi2 <= y_next[3];
            end
        end
    end

    assign out_valid = s2_valid;

    // a clamp in the same cycle as ovf_clr must not be lost, so set takes priority
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (s2_load && (|sat)) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_butterfly_cplx_pipe.sv
module tb_butterfly_cplx_pipe;

    localparam int DW = 16;

    typedef struct packed {
        logic [DW-1:0] yr1;
        logic [DW-1:0] yi1;
        logic [DW-1:0] yr2;
        logic [DW-1:0] yi2;
        logic          sat;
    } res_t;

    typedef struct packed {
        res_t e0;
        res_t e1;
    } exp_t;

    typedef struct packed {
        int ar, ai, br, bi, tw;
        int r1_0, i1_0, r2_0, i2_0;
        int r1_1, i1_1, r2_1, i2_1;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic ovf_clr = 1'b0;
    logic [1:0] tw_sel = '0;
    logic signed [DW-1:0] ar_d = '0, ai_d = '0, br_d = '0, bi_d = '0;

    logic in_ready0, out_valid0, ovf0;
    logic in_ready1, out_valid1, ovf1;
    logic signed [DW-1:0] yr1_0, yi1_0, yr2_0, yi2_0;
    logic signed [DW-1:0] yr1_1, yi1_1, yr2_1, yi2_1;

    int   checks = 0;
    int   errors = 0;
    int   popped = 0;
    exp_t q[$];
    exp_t cur;
    bit   m1 = 1'b0, m2 = 1'b0, ovf_m = 1'b0;
    vec_t tbl[6];

    always #5 clk = ~clk;

    butterfly_cplx_pipe #(.DW(DW), .SCALE(1'b0)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .ar(ar_d), .ai(ai_d), .br(br_d), .bi(bi_d), .tw_sel(tw_sel),
        .out_valid(out_valid0), .out_ready(out_ready),
        .yr1(yr1_0), .yi1(yi1_0), .yr2(yr2_0), .yi2(yi2_0),
        .ovf(ovf0), .ovf_clr(ovf_clr)
    );

    butterfly_cplx_pipe #(.DW(DW), .SCALE(1'b1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .ar(ar_d), .ai(ai_d), .br(br_d), .bi(bi_d), .tw_sel(tw_sel),
        .out_valid(out_valid1), .out_ready(out_ready),
        .yr1(yr1_1), .yi1(yi1_1), .yr2(yr2_1), .yi2(yi2_1),
        .ovf(ovf1), .ovf_clr(ovf_clr)
    );

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic res_t model(int a_r, int a_i, int b_r, int b_i, int tw, bit scale);
        int   rr, ri, v;
        int   s[4];
        logic [DW-1:0] o[4];
        res_t e;
        case (tw)
            0:       begin rr = b_r;  ri = b_i;  end
            1:       begin rr = b_i;  ri = -b_r; end
            2:       begin rr = -b_r; ri = -b_i; end
            default: begin rr = -b_i; ri = b_r;  end
        endcase
        s[0] = a_r + rr;
        s[1] = a_i + ri;
        s[2] = a_r - rr;
        s[3] = a_i - ri;
        e.sat = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (scale) begin
                v = s[k] >>> 1;
            end else begin
                v = s[k];
                if (v > 32767) begin
                    v = 32767;
                    e.sat = 1'b1;
                end else if (v < -32768) begin
                    v = -32768;
                    e.sat = 1'b1;
                end
            end
            o[k] = v[DW-1:0];
        end
        e.yr1 = o[0];
        e.yi1 = o[1];
        e.yr2 = o[2];
        e.yi2 = o[3];
        return e;
    endfunction

    task automatic set_in(int a_r, int a_i, int b_r, int b_i, int tw);
        ar_d   = a_r[DW-1:0];
        ai_d   = a_i[DW-1:0];
        br_d   = b_r[DW-1:0];
        bi_d   = b_i[DW-1:0];
        tw_sel = tw[1:0];
        cur.e0 = model(a_r, a_i, b_r, b_i, tw, 1'b0);
        cur.e1 = model(a_r, a_i, b_r, b_i, tw, 1'b1);
    endtask

    // one clock: check handshake/outputs against the model, then track the edge
    task automatic step(output bit acc);
        bit in_x, adv1, adv2, set0;
        #1;
        chk("in_ready_s0", in_ready0, !(q.size() == 2 && !out_ready));
        chk("in_ready_s1", in_ready1, !(q.size() == 2 && !out_ready));
        chk("out_valid_s0", out_valid0, m2);
        chk("out_valid_s1", out_valid1, m2);
        chk("ovf_s0", ovf0, ovf_m);
        chk("ovf_s1", ovf1, 0);
        if (m2) begin
            if (q.size() == 0) begin
                chk("scoreboard_nonempty", 0, 1);
            end else begin
                chk("yr1_s0", yr1_0, $signed(q[0].e0.yr1));
                chk("yi1_s0", yi1_0, $signed(q[0].e0.yi1));
                chk("yr2_s0", yr2_0, $signed(q[0].e0.yr2));
                chk("yi2_s0", yi2_0, $signed(q[0].e0.yi2));
                chk("yr1_s1", yr1_1, $signed(q[0].e1.yr1));
                chk("yi1_s1", yi1_1, $signed(q[0].e1.yi1));
                chk("yr2_s1", yr2_1, $signed(q[0].e1.yr2));
                chk("yi2_s1", yi2_1, $signed(q[0].e1.yi2));
            end
        end
        adv2 = !m2 || out_ready;
        adv1 = !m1 || adv2;
        in_x = in_valid && adv1;
        set0 = 1'b0;
        if (m1 && adv2 && q.size() > 0) set0 = q[q.size()-1].e0.sat;
        @(posedge clk);
        if (set0) ovf_m = 1'b1;
        else if (ovf_clr) ovf_m = 1'b0;
        if (m2 && out_ready && q.size() > 0) begin
            void'(q.pop_front());
            popped++;
        end
        if (in_x) q.push_back(cur);
        m2 = adv2 ? m1 : m2;
        m1 = adv1 ? in_x : m1;
        acc = in_x;
        @(negedge clk);
    endtask

    task automatic apply_vec(int i);
        bit acc;
        set_in(tbl[i].ar, tbl[i].ai, tbl[i].br, tbl[i].bi, tbl[i].tw);
        cur.e0.yr1 = 16'(tbl[i].r1_0);
        cur.e0.yi1 = 16'(tbl[i].i1_0);
        cur.e0.yr2 = 16'(tbl[i].r2_0);
        cur.e0.yi2 = 16'(tbl[i].i2_0);
        cur.e1.yr1 = 16'(tbl[i].r1_1);
        cur.e1.yi1 = 16'(tbl[i].i1_1);
        cur.e1.yr2 = 16'(tbl[i].r2_1);
        cur.e1.yi2 = 16'(tbl[i].i2_1);
        in_valid = 1'b1;
        step(acc);
        chk("vec_accepted", acc, 1);
    endtask

    task automatic drain();
        bit acc;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 10 && (q.size() > 0 || m1 || m2); n++) step(acc);
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        bit pat[8];
        int idx;

        //          ar     ai      br      bi  tw | SCALE=0 y1r,y1i,y2r,y2i | SCALE=1 y1r,y1i,y2r,y2i
        tbl[0] = '{100,    50,     10,     20, 0,  110,     70,  90,     30,  55,     35,  45,     15};
        tbl[1] = '{100,    50,     10,     20, 1,  120,     40,  80,     60,  60,     20,  40,     30};
        tbl[2] = '{100,    50,     10,     20, 2,   90,     30, 110,     70,  45,     15,  55,     35};
        tbl[3] = '{100,    50,     10,     20, 3,   80,     60, 120,     40,  40,     30,  60,     20};
        tbl[4] = '{32767, -32768,   1,      1, 0, 32767, -32767, 32766, -32768, 16384, -16384, 16383, -16385};
        tbl[5] = '{0,       0, -32768,      0, 2, 32767,      0, -32768,     0, 16384,      0, -16384,      0};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

        // reset held with in_valid asserted
        rst = 1'b0;
        in_valid = 1'b1;
        set_in(5, 5, 5, 5, 0);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid_s0", out_valid0, 0);
        chk("rst_out_valid_s1", out_valid1, 0);
        chk("rst_yr1", yr1_0, 0);
        chk("rst_yi1", yi1_0, 0);
        chk("rst_yr2", yr2_0, 0);
        chk("rst_yi2", yi2_0, 0);
        chk("rst_ovf", ovf0, 0);
        chk("rst_in_ready", in_ready0, 1);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;

        // twiddles back-to-back, outputs on consecutive cycles
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) apply_vec(i);
        drain();
        chk("ovf_no_sat", ovf0, 0);

        // saturation and sticky flag
        apply_vec(4);
        drain();
        chk("ovf_set", ovf0, 1);
        chk("ovf_scaled", ovf1, 0);
        repeat (3) step(acc);
        chk("ovf_sticky", ovf0, 1);
        ovf_clr = 1'b1;
        step(acc);
        ovf_clr = 1'b0;
        chk("ovf_cleared", ovf0, 0);

        // clear and new saturation in the same cycle: set wins
        ovf_clr = 1'b1;
        apply_vec(4);
        in_valid = 1'b0;
        step(acc);
        chk("ovf_set_wins", ovf0, 1);
        ovf_clr = 1'b0;
        drain();
        ovf_clr = 1'b1;
        step(acc);
        ovf_clr = 1'b0;

        // negation corner
        apply_vec(5);
        drain();
        chk("neg_ovf_scaled", ovf1, 0);

        // back-pressure stream of 8 random samples
        popped = 0;
        idx = 0;
        set_in($urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
               $urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
               $urandom_range(0, 3));
        for (int c = 0; c < 80 && !(idx == 8 && q.size() == 0); c++) begin
            out_ready = pat[c % 8];
            in_valid  = (idx < 8);
            step(acc);
            if (acc) begin
                idx++;
                set_in($urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
                       $urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
                       $urandom_range(0, 3));
            end
        end
        chk("bp_inputs", idx, 8);
        chk("bp_outputs", popped, 8);
        drain();

        // mid-stream reset with two samples in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_in(1000, -1000, 300, 400, 1);
        step(acc);
        set_in(-2000, 2000, 500, -600, 3);
        step(acc);
        chk("mid_inflight", q.size(), 2);
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid_s0", out_valid0, 0);
        chk("mid_rst_out_valid_s1", out_valid1, 0);
        q.delete();
        m1 = 1'b0;
        m2 = 1'b0;
        ovf_m = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) step(acc);
        apply_vec(0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
